// File: rtl/boolean_truth_checker.sv
// On-chip exhaustive checker for a 3-input combinational block. It walks {a,b,c}
// through 000..111, samples f after SETTLE cycles per vector and scores it against EXPECT.
module boolean_truth_checker #(
  parameter logic [7:0]  EXPECT = 8'hE8,
  parameter int unsigned SETTLE = 2      // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [7:0] fail_mask,
  output logic [2:0] first_fail_idx,
  output logic       first_fail_valid
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic [7:0] fail_mask_q, fail_mask_d;
  logic [2:0] ffi_q, ffi_d;
  logic       ffv_q, ffv_d;
  logic       mismatch;
  logic [3:0] count_next;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    abc_d        = abc_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_mask_d  = fail_mask_q;
    ffi_d        = ffi_q;
    ffv_d        = ffv_q;
    mismatch     = 1'b0;
    count_next   = fail_count_q;

    case (state_q)
      IDLE: begin
        abc_d = 3'b000;
        if (start) begin
          state_d      = RUN;
          idx_d        = 3'd0;
          cnt_d        = 4'd0;
          pass_d       = 1'b0;
          fail_count_d = 4'd0;
          fail_mask_d  = 8'h00;
          ffi_d        = 3'd0;
          ffv_d        = 1'b0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          mismatch = (f != EXPECT[idx_q]);
          if (mismatch) begin
            count_next         = fail_count_q + 4'd1;
            fail_count_d       = count_next;
            fail_mask_d[idx_q] = 1'b1;
            if (!ffv_q) begin
              ffi_d = idx_q;
              ffv_d = 1'b1;
            end
          end
          // Last vector scored: the pass verdict includes this sample's result.
          if (idx_q != 3'd7) begin
            idx_d = idx_q + 3'd1;
            cnt_d = 4'd0;
            abc_d = idx_q + 3'd1;
          end else begin
            state_d = IDLE;
            idx_d   = 3'd0;
            cnt_d   = 4'd0;
            abc_d   = 3'b000;
            done_d  = 1'b1;
            pass_d  = (count_next == 4'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 4'd0;
      abc_q        <= 3'b000;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 4'd0;
      fail_mask_q  <= 8'h00;
      ffi_q        <= 3'd0;
      ffv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      abc_q        <= abc_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_mask_q  <= fail_mask_d;
      ffi_q        <= ffi_d;
      ffv_q        <= ffv_d;
    end
  end

  assign a                = abc_q[2];
  assign b                = abc_q[1];
  assign c                = abc_q[0];
  assign busy             = (state_q == RUN);
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_count_q;
  assign fail_mask        = fail_mask_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_boolean_truth_checker.sv
// Bench for boolean_truth_checker: two instances (SETTLE=2 and SETTLE=5) driven by a
// selectable reference block; a monitor scores every done pulse against queued expectations.
module tb_boolean_truth_checker;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Block-under-test model: 0 = majority, 1 = stuck at 0, 2 = majority with vector 0 forced to 1
  int mode = 0;
  function automatic logic model(input int m, input logic [2:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      1:       return 1'b0;
      2:       return (v == 3'd0) ? 1'b1 : maj;
      default: return maj;
    endcase
  endfunction

  // ---------------- DUT (SETTLE=2) ----------------
  logic       start = 1'b0;
  logic       f, a, b, c, busy, done, pass, ffv;
  logic [3:0] fail_count;
  logic [7:0] fail_mask;
  logic [2:0] ffi;
  assign f = model(mode, {a, b, c});

  boolean_truth_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f(f),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .fail_mask(fail_mask),
    .first_fail_idx(ffi), .first_fail_valid(ffv)
  );

  // ---------------- DUT (SETTLE=5) ----------------
  logic       start5 = 1'b0;
  logic       f5, a5, b5, c5, busy5, done5, pass5, ffv5;
  logic [3:0] fail_count5;
  logic [7:0] fail_mask5;
  logic [2:0] ffi5;
  assign f5 = model(mode, {a5, b5, c5});

  boolean_truth_checker #(.EXPECT(8'hE8), .SETTLE(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .f(f5),
    .a(a5), .b(b5), .c(c5), .busy(busy5), .done(done5), .pass(pass5),
    .fail_count(fail_count5), .fail_mask(fail_mask5),
    .first_fail_idx(ffi5), .first_fail_valid(ffv5)
  );

  // Result word: {pass, fail_count, fail_mask, first_fail_idx, first_fail_valid}
  wire [16:0] res  = {pass, fail_count, fail_mask, ffi, ffv};
  wire [16:0] res5 = {pass5, fail_count5, fail_mask5, ffi5, ffv5};
  wire [22:0] all_out = {a, b, c, busy, done, res};
  wire [22:0] all_out5 = {a5, b5, c5, busy5, done5, res5};

  function automatic logic [16:0] pk(input logic p, input logic [3:0] n, input logic [7:0] m,
                                     input logic [2:0] i, input logic v);
    return {p, n, m, i, v};
  endfunction

  localparam logic [16:0] R_OK    = 17'b1_0000_00000000_000_0;  // pass, 0 fails
  localparam logic [16:0] R_STUCK = 17'b0_0100_11101000_011_1;  // 4 fails, mask E8, first 3
  localparam logic [16:0] R_V0    = 17'b0_0001_00000001_000_1;  // 1 fail, mask 01, first 0

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int          tq[$];
  logic [16:0] exp5_q[$];
  int          t5q[$];

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("result", 32'(res), 32'(exp_q.pop_front()));
        check("done_cycle", 32'(cyc), 32'(tq.pop_front()));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (rst_n && done5) begin
      if (exp5_q.size() == 0) begin
        check("unexpected_done5", 32'd1, 32'd0);
      end else begin
        check("result5", 32'(res5), 32'(exp5_q.pop_front()));
        check("done_cycle5", 32'(cyc), 32'(t5q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: the next posedge is edge cyc+1 and done follows 8*SETTLE edges later.
  task automatic issue(input bit sel5, input logic [16:0] exp);
    if (sel5) begin
      start5 = 1'b1;
      exp5_q.push_back(exp);
      t5q.push_back(cyc + 1 + 8 * 5);
      @(negedge clk);
      start5 = 1'b0;
    end else begin
      start = 1'b1;
      exp_q.push_back(exp);
      tq.push_back(cyc + 1 + 8 * 2);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp5_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(exp_q.size() + exp5_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset state
    #2;
    check("reset_outputs", 32'(all_out), 32'd0);
    check("reset_outputs5", 32'(all_out5), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 2: correct majority, vector walk and timing
    mode = 0;
    issue(1'b0, R_OK);
    for (int j = 0; j < 16; j++) begin
      check("abc_walk", 32'({a, b, c}), 32'(j / 2));
      check("busy_run", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check("abc_after", 32'({a, b, c}), 32'd0);
    drain("maj");

    // 3: stuck-at-0, results held after done
    mode = 1;
    issue(1'b0, R_STUCK);
    drain("stuck");
    repeat (3) @(negedge clk);
    check("result_hold", 32'(res), 32'(R_STUCK));

    // 4: vector 0 forced high, SETTLE=2 and SETTLE=5
    mode = 2;
    issue(1'b0, R_V0);
    drain("v0");
    issue(1'b1, R_V0);
    drain("v0_s5");

    // 5: start held high, stuck model so clearing on re-accept is visible
    mode = 1;
    start = 1'b1;
    exp_q.push_back(R_STUCK);
    tq.push_back(cyc + 1 + 16);
    exp_q.push_back(R_STUCK);
    tq.push_back(cyc + 18 + 16);
    repeat (18) @(negedge clk);
    start = 1'b0;
    check("clear_on_restart", 32'(res), 32'(pk(1'b0, 4'd0, 8'h00, 3'd0, 1'b0)));
    check("busy_restart", 32'(busy), 32'd1);
    drain("held");

    // 6: reset during vector 3 aborts the run without done
    mode = 0;
    issue(1'b0, R_OK);
    repeat (6) @(negedge clk);
    check("abc_before_abort", 32'({a, b, c}), 32'd3);
    #3 rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'(all_out), 32'd0);
    exp_q.delete();
    tq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    issue(1'b0, R_OK);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
